// File: rtl/gmem_cu_arbiter.sv
// Round-robin merge of N_CU compute-unit request streams into the single
// gmem_cntrl request port, through one registered output slot.
module gmem_cu_arbiter #(
  parameter int unsigned N_CU    = 4,
  parameter int unsigned N_CU_W  = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned SGNTR_W = 6
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [N_CU-1:0]            in_valid,
  output logic [N_CU-1:0]            in_ready,
  input  logic [N_CU*DATA_W/8-1:0]   in_we,
  input  logic [N_CU-1:0]            in_rnw,
  input  logic [N_CU-1:0]            in_atomic,
  input  logic [N_CU*SGNTR_W-1:0]    in_sgntr,
  input  logic [N_CU*ADDR_W-1:0]     in_addr,
  input  logic [N_CU*DATA_W-1:0]     in_wrData,
  output logic                       cu_valid,
  input  logic                       cu_ready,
  output logic [DATA_W/8-1:0]        cu_we,
  output logic                       cu_rnw,
  output logic                       cu_atomic,
  output logic [SGNTR_W-1:0]         cu_atomic_sgntr,
  output logic [ADDR_W-1:0]          cu_rqst_addr,
  output logic [DATA_W-1:0]          cu_wrData,
  output logic [N_CU_W-1:0]          cu_src,
  output logic                       arb_idle
);

  localparam int unsigned WeW = DATA_W / 8;

  typedef enum logic {StEmpty, StFull} slot_e;

  slot_e               slot_q, slot_d;
  logic [N_CU_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic                slot_free;
  logic                found;
  logic                grant;
  logic [N_CU_W-1:0]   win;
  logic [N_CU_W-1:0]   idx_w;
  int unsigned         idx;

  logic [WeW-1:0]      sel_we;
  logic                sel_rnw;
  logic                sel_atomic;
  logic [SGNTR_W-1:0]  sel_sgntr;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  assign cu_valid  = (slot_q == StFull);
  assign slot_free = (slot_q == StEmpty) || cu_ready;
  // in_ready must stay low while reset is asserted, so the grant is gated by nrst
  assign grant     = nrst && slot_free && found;
  assign arb_idle  = !cu_valid && !(|in_valid);

  // Round-robin search: first valid index at or after rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    idx_w = '0;
    for (int unsigned k = 0; k < N_CU; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= N_CU) idx = idx - N_CU;
      idx_w = N_CU_W'(idx);
      if (!found && in_valid[idx_w]) begin
        found = 1'b1;
        win   = idx_w;
      end
    end
  end

  // One-hot accept strobe back to the winning CU
  always_comb begin
    in_ready = '0;
    if (grant) in_ready[win] = 1'b1;
  end

  // Select the winner's request fields
  always_comb begin
    sel_we     = '0;
    sel_rnw    = 1'b0;
    sel_atomic = 1'b0;
    sel_sgntr  = '0;
    sel_addr   = '0;
    sel_data   = '0;
    for (int unsigned i = 0; i < N_CU; i++) begin
      if (N_CU_W'(i) == win) begin
        sel_we     = in_we[i*WeW +: WeW];
        sel_rnw    = in_rnw[i];
        sel_atomic = in_atomic[i];
        sel_sgntr  = in_sgntr[i*SGNTR_W +: SGNTR_W];
        sel_addr   = in_addr[i*ADDR_W +: ADDR_W];
        sel_data   = in_wrData[i*DATA_W +: DATA_W];
      end
    end
  end

  // Slot occupancy and pointer next state; pointer only advances on a grant
  always_comb begin
    slot_d   = slot_q;
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      slot_d   = StFull;
      rr_ptr_d = (win == N_CU_W'(N_CU - 1)) ? '0 : win + 1'b1;
    end else if (cu_ready) begin
      slot_d = StEmpty;
    end
  end

  // Output slot register; fields load only on a grant so a stalled request holds
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      slot_q          <= StEmpty;
      rr_ptr_q        <= '0;
      cu_we           <= '0;
      cu_rnw          <= 1'b0;
      cu_atomic       <= 1'b0;
      cu_atomic_sgntr <= '0;
      cu_rqst_addr    <= '0;
      cu_wrData       <= '0;
      cu_src          <= '0;
    end else begin
      slot_q   <= slot_d;
      rr_ptr_q <= rr_ptr_d;
      if (grant) begin
        cu_we           <= sel_we;
        cu_rnw          <= sel_rnw;
        cu_atomic       <= sel_atomic;
        cu_atomic_sgntr <= sel_sgntr;
        cu_rqst_addr    <= sel_addr;
        cu_wrData       <= sel_data;
        cu_src          <= win;
      end
    end
  end

endmodule

// File: tb/tb_gmem_cu_arbiter.sv
// Self-checking bench for gmem_cu_arbiter: directed scenarios plus a
// randomized run against a behavioural round-robin model.
module tb_gmem_cu_arbiter;

  localparam int N = 4;
  localparam int DW = 32;
  localparam int AW = 30;
  localparam int SW = 6;

  logic            clk = 1'b0;
  logic            nrst;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N*4-1:0]  in_we;
  logic [N-1:0]    in_rnw;
  logic [N-1:0]    in_atomic;
  logic [N*SW-1:0] in_sgntr;
  logic [N*AW-1:0] in_addr;
  logic [N*DW-1:0] in_wrData;
  logic            cu_valid;
  logic            cu_ready;
  logic [3:0]      cu_we;
  logic            cu_rnw;
  logic            cu_atomic;
  logic [SW-1:0]   cu_atomic_sgntr;
  logic [AW-1:0]   cu_rqst_addr;
  logic [DW-1:0]   cu_wrData;
  logic [1:0]      cu_src;
  logic            arb_idle;

  int checks = 0;
  int errors = 0;

  gmem_cu_arbiter #(
    .N_CU(N), .N_CU_W(2), .DATA_W(DW), .ADDR_W(AW), .SGNTR_W(SW)
  ) dut (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_rnw(in_rnw),
    .in_atomic(in_atomic), .in_sgntr(in_sgntr), .in_addr(in_addr), .in_wrData(in_wrData),
    .cu_valid(cu_valid), .cu_ready(cu_ready), .cu_we(cu_we), .cu_rnw(cu_rnw),
    .cu_atomic(cu_atomic), .cu_atomic_sgntr(cu_atomic_sgntr), .cu_rqst_addr(cu_rqst_addr),
    .cu_wrData(cu_wrData), .cu_src(cu_src), .arb_idle(arb_idle)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int cu, input logic [3:0] we, input logic rnw, input logic at,
                         input logic [SW-1:0] sg, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    in_we[cu*4 +: 4]       = we;
    in_rnw[cu]             = rnw;
    in_atomic[cu]          = at;
    in_sgntr[cu*SW +: SW]  = sg;
    in_addr[cu*AW +: AW]   = a;
    in_wrData[cu*DW +: DW] = d;
  endtask

  task automatic do_reset;
    nrst = 1'b0;
    in_valid = '0;
    #2;
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    nrst = 1'b0; in_valid = 4'hF; cu_ready = 1'b1;
    in_we = '0; in_rnw = '0; in_atomic = '0; in_sgntr = '0; in_addr = '0; in_wrData = '0;
    #3;
    checks++; if (in_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_in_ready: got %b exp 0000", in_ready); end
    checks++; if (cu_valid !== 1'b0) begin
      errors++; $display("FAIL reset_cu_valid: got %b exp 0", cu_valid); end
    checks++; if (cu_src !== 2'd0 || cu_wrData !== 32'd0 || cu_rqst_addr !== 30'd0) begin
      errors++; $display("FAIL reset_fields: src %0d data %h addr %h exp all 0",
                         cu_src, cu_wrData, cu_rqst_addr); end
    in_valid = '0;
    tick();
    nrst = 1'b1;
    #1;
    checks++; if (arb_idle !== 1'b1) begin
      errors++; $display("FAIL reset_idle: got %b exp 1", arb_idle); end
    tick();
  endtask

  // rr_ptr = 0 on entry
  task automatic test_single_write;
    set_req(2, 4'hF, 1'b0, 1'b0, 6'h0, 30'h1004, 32'hcafecafe);
    in_valid = 4'b0100; cu_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0100) begin
      errors++; $display("FAIL single_ready: got %b exp 0100", in_ready); end
    tick();
    in_valid = '0;
    checks++; if (cu_valid !== 1'b1 || cu_src !== 2'd2) begin
      errors++; $display("FAIL single_out: valid %b src %0d exp 1/2", cu_valid, cu_src); end
    checks++; if (cu_we !== 4'hF || cu_rqst_addr !== 30'h1004 || cu_wrData !== 32'hcafecafe
                  || cu_rnw !== 1'b0) begin
      errors++; $display("FAIL single_fields: we %h addr %h data %h rnw %b exp F/1004/cafecafe/0",
                         cu_we, cu_rqst_addr, cu_wrData, cu_rnw); end
    tick();
    checks++; if (cu_valid !== 1'b0) begin
      errors++; $display("FAIL single_once: cu_valid %b exp 0", cu_valid); end
  endtask

  task automatic test_fairness;
    do_reset();
    in_valid = 4'hF; cu_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (in_ready !== 4'(1 << (i % 4))) begin
        errors++; $display("FAIL fair_ready[%0d]: got %b exp %b", i, in_ready, 4'(1 << (i % 4)));
      end
      tick();
      checks++; if (cu_valid !== 1'b1 || cu_src !== 2'(i % 4)) begin
        errors++; $display("FAIL fair_src[%0d]: valid %b src %0d exp 1/%0d", i, cu_valid,
                           cu_src, i % 4); end
    end
  endtask

  // Slot FULL with src 3 and rr_ptr = 0 on entry
  task automatic test_backpressure;
    set_req(0, 4'h1, 1'b0, 1'b0, 6'h0, 30'h100, 32'h0000d000);
    set_req(1, 4'h2, 1'b0, 1'b0, 6'h0, 30'h104, 32'h0000d111);
    in_valid = 4'b0011; cu_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0001) begin
      errors++; $display("FAIL bp_first_ready: got %b exp 0001", in_ready); end
    tick();
    cu_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (in_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_stall_ready[%0d]: got %b exp 0000", i, in_ready); end
      tick();
      checks++; if (cu_valid !== 1'b1 || cu_src !== 2'd0 || cu_wrData !== 32'h0000d000
                    || cu_rqst_addr !== 30'h100) begin
        errors++; $display("FAIL bp_hold[%0d]: valid %b src %0d data %h exp 1/0/0000d000",
                           i, cu_valid, cu_src, cu_wrData); end
    end
    cu_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0010) begin
      errors++; $display("FAIL bp_release_ready: got %b exp 0010", in_ready); end
    tick();
    in_valid = '0;
    checks++; if (cu_valid !== 1'b1 || cu_src !== 2'd1 || cu_wrData !== 32'h0000d111) begin
      errors++; $display("FAIL bp_next: valid %b src %0d data %h exp 1/1/0000d111",
                         cu_valid, cu_src, cu_wrData); end
    tick();
  endtask

  // rr_ptr = 2 and slot empty on entry
  task automatic test_wrap_skip;
    in_valid = 4'b1010; cu_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b1000) begin
      errors++; $display("FAIL wrap_ready0: got %b exp 1000", in_ready); end
    tick();
    checks++; if (cu_src !== 2'd3) begin
      errors++; $display("FAIL wrap_src0: got %0d exp 3", cu_src); end
    #1;
    checks++; if (in_ready !== 4'b0010) begin
      errors++; $display("FAIL wrap_ready1: got %b exp 0010", in_ready); end
    tick();
    checks++; if (cu_src !== 2'd1) begin
      errors++; $display("FAIL wrap_src1: got %0d exp 1", cu_src); end
    #1;
    checks++; if (in_ready !== 4'b1000) begin
      errors++; $display("FAIL wrap_ptr2: got %b exp 1000", in_ready); end
    tick();
    in_valid = '0;
    tick();
  endtask

  // rr_ptr = 0 on entry
  task automatic test_atomic;
    set_req(1, 4'h0, 1'b1, 1'b1, 6'h2A, 30'h55, 32'h0);
    in_valid = 4'b0010; cu_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0010) begin
      errors++; $display("FAIL atomic_ready: got %b exp 0010", in_ready); end
    tick();
    in_valid = '0;
    #1;
    checks++; if (cu_atomic !== 1'b1 || cu_atomic_sgntr !== 6'h2A || cu_src !== 2'd1
                  || cu_rnw !== 1'b1) begin
      errors++; $display("FAIL atomic_fields: at %b sg %h src %0d rnw %b exp 1/2a/1/1",
                         cu_atomic, cu_atomic_sgntr, cu_src, cu_rnw); end
    checks++; if (arb_idle !== 1'b0) begin
      errors++; $display("FAIL atomic_busy: arb_idle %b exp 0", arb_idle); end
    tick();
    checks++; if (cu_valid !== 1'b0 || arb_idle !== 1'b1) begin
      errors++; $display("FAIL atomic_drain: valid %b idle %b exp 0/1", cu_valid, arb_idle); end
  endtask

  // rr_ptr = 2 on entry; stalled CU2 request moves the pointer to 3 before reset
  task automatic test_reset_mid;
    set_req(2, 4'h3, 1'b0, 1'b0, 6'h0, 30'h200, 32'h12345678);
    in_valid = 4'b0100; cu_ready = 1'b0;
    tick();
    in_valid = '0;
    tick();
    checks++; if (cu_valid !== 1'b1) begin
      errors++; $display("FAIL rmid_full: cu_valid %b exp 1", cu_valid); end
    in_valid = 4'b0100;
    nrst = 1'b0;
    #1;
    checks++; if (cu_valid !== 1'b0 || in_ready !== 4'b0000) begin
      errors++; $display("FAIL rmid_clear: valid %b ready %b exp 0/0000", cu_valid, in_ready); end
    checks++; if (cu_src !== 2'd0 || cu_wrData !== 32'd0) begin
      errors++; $display("FAIL rmid_fields: src %0d data %h exp 0/0", cu_src, cu_wrData); end
    in_valid = 4'b1010; cu_ready = 1'b1;
    nrst = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0010) begin
      errors++; $display("FAIL rmid_ptr: got %b exp 0010", in_ready); end
    tick();
    checks++; if (cu_valid !== 1'b1 || cu_src !== 2'd1) begin
      errors++; $display("FAIL rmid_grant: valid %b src %0d exp 1/1", cu_valid, cu_src); end
    in_valid = '0;
    tick();
  endtask

  task automatic test_random;
    int        m_rr, m_src, exp_w;
    logic      m_valid, exp_grant;
    logic [3:0] m_we, exp_ready;
    logic      m_rnw, m_at;
    logic [SW-1:0] m_sg;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int        c;
    do_reset();
    m_rr = 0; m_valid = 1'b0; m_src = 0;
    m_we = '0; m_rnw = 1'b0; m_at = 1'b0; m_sg = '0; m_addr = '0; m_data = '0;
    for (int n = 0; n < 400; n++) begin
      in_valid = 4'($urandom_range(0, 15));
      cu_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++)
        set_req(i, 4'($urandom), 1'($urandom), 1'($urandom), 6'($urandom), 30'($urandom),
                $urandom);
      #1;
      exp_grant = 1'b0; exp_w = 0;
      if (!m_valid || cu_ready) begin
        for (int k = 0; k < N; k++) begin
          c = (m_rr + k) % N;
          if (!exp_grant && in_valid[c]) begin exp_grant = 1'b1; exp_w = c; end
        end
      end
      exp_ready = exp_grant ? 4'(1 << exp_w) : 4'b0000;
      checks++; if (in_ready !== exp_ready) begin
        errors++; $display("FAIL rand_ready[%0d]: got %b exp %b", n, in_ready, exp_ready); end
      checks++; if (arb_idle !== (!m_valid && in_valid == 4'b0000)) begin
        errors++; $display("FAIL rand_idle[%0d]: got %b exp %b", n, arb_idle,
                           (!m_valid && in_valid == 4'b0000)); end
      if (exp_grant) begin
        m_valid = 1'b1; m_src = exp_w; m_rr = (exp_w + 1) % N;
        m_we = in_we[exp_w*4 +: 4]; m_rnw = in_rnw[exp_w]; m_at = in_atomic[exp_w];
        m_sg = in_sgntr[exp_w*SW +: SW]; m_addr = in_addr[exp_w*AW +: AW];
        m_data = in_wrData[exp_w*DW +: DW];
      end else if (cu_ready) begin
        m_valid = 1'b0;
      end
      tick();
      checks++; if (cu_valid !== m_valid) begin
        errors++; $display("FAIL rand_valid[%0d]: got %b exp %b", n, cu_valid, m_valid); end
      if (m_valid) begin
        checks++; if (cu_src !== 2'(m_src) || cu_wrData !== m_data || cu_rqst_addr !== m_addr
                      || cu_we !== m_we || cu_rnw !== m_rnw || cu_atomic !== m_at
                      || cu_atomic_sgntr !== m_sg) begin
          errors++; $display("FAIL rand_fields[%0d]: src %0d data %h addr %h exp %0d/%h/%h",
                             n, cu_src, cu_wrData, cu_rqst_addr, m_src, m_data, m_addr); end
      end
    end
    in_valid = '0; cu_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fairness();
    test_backpressure();
    test_wrap_skip();
    test_atomic();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
